// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the signed-overflow flag helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Overflow occurs only when the operand signs differ and the result sign
    // disagrees with the minuend sign.
    function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_subtractor1bit.sv
// Combinational one-bit full-subtractor cell: diff = in1 - in2 - bin.
module subtractor1bit (
    output logic diff,
    output logic bout,
    input  logic in1,
    input  logic in2,
    input  logic bin
);

    assign diff = in1 ^ in2 ^ bin;
    assign bout = (~in1 & in2) | (~in1 & bin) | (in2 & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell processes the
// operands LSB first, one bit per clock, behind valid/ready handshakes.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_bout,
    output logic             out_zero,
    output logic             out_ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;
    logic             r_ovf;

    logic             w_diff_bit;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    subtractor1bit u_cell (
        .diff (w_diff_bit),
        .bout (w_bout),
        .in1  (r_a_sr[0]),
        .in2  (r_b_sr[0]),
        .bin  (r_borrow)
    );

    assign w_last    = (r_state == ST_RUN) && (r_cnt == CW'(WIDTH - 1));
    assign out_valid = (r_state == ST_DONE);
    assign out_diff  = r_diff;
    assign out_bout  = r_bout;
    assign out_zero  = r_zero;
    assign out_ovf   = r_ovf;

    // Result register after this cycle's bit enters from the MSB end.
    always_comb begin
        w_res_next            = r_res >> 1;
        w_res_next[WIDTH-1]   = w_diff_bit;
    end

    // Next-state logic and input-side ready.
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    w_next = ST_RUN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_DONE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath: operand load, serial shift, and result/flag capture on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sr   <= in_a;
                        r_b_sr   <= in_b;
                        r_res    <= '0;
                        r_borrow <= in_bin;
                        r_a_msb  <= in_a[WIDTH-1];
                        r_b_msb  <= in_b[WIDTH-1];
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_res    <= w_res_next;
                    r_borrow <= w_bout;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff <= w_res_next;
                        r_bout <= w_bout;
                        r_zero <= (w_res_next == '0);
                        r_ovf  <= ovf_flag(r_a_msb, r_b_msb, w_diff_bit);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: three widths (8, 1, 16) checked against an arithmetic
// reference model, with directed cases followed by a randomized sweep.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv   [3];
    logic [15:0] ia   [3];
    logic [15:0] ib   [3];
    logic        ibin [3];
    logic        ordy [3];

    logic        rdy8, val8, bo8, zr8, of8;
    logic [7:0]  d8;
    logic        rdy1, val1, bo1, zr1, of1;
    logic [0:0]  d1;
    logic        rdy16, val16, bo16, zr16, of16;
    logic [15:0] d16;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy8),
        .in_a(ia[0][7:0]), .in_b(ib[0][7:0]), .in_bin(ibin[0]),
        .out_valid(val8), .out_ready(ordy[0]), .out_diff(d8),
        .out_bout(bo8), .out_zero(zr8), .out_ovf(of8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy1),
        .in_a(ia[1][0:0]), .in_b(ib[1][0:0]), .in_bin(ibin[1]),
        .out_valid(val1), .out_ready(ordy[1]), .out_diff(d1),
        .out_bout(bo1), .out_zero(zr1), .out_ovf(of1)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy16),
        .in_a(ia[2]), .in_b(ib[2]), .in_bin(ibin[2]),
        .out_valid(val16), .out_ready(ordy[2]), .out_diff(d16),
        .out_bout(bo16), .out_zero(zr16), .out_ovf(of16)
    );

    typedef struct packed {
        logic        ready;
        logic        valid;
        logic        bout;
        logic        zero;
        logic        ovf;
        logic [15:0] diff;
    } obs_t;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int wd(input int k);
        case (k)
            0:       return 8;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    function automatic obs_t obs(input int k);
        obs_t o;
        o = '0;
        case (k)
            0: begin
                o.ready = rdy8; o.valid = val8; o.bout = bo8; o.zero = zr8; o.ovf = of8;
                o.diff = {8'd0, d8};
            end
            1: begin
                o.ready = rdy1; o.valid = val1; o.bout = bo1; o.zero = zr1; o.ovf = of1;
                o.diff = {15'd0, d1};
            end
            default: begin
                o.ready = rdy16; o.valid = val16; o.bout = bo16; o.zero = zr16; o.ovf = of16;
                o.diff = d16;
            end
        endcase
        return o;
    endfunction

    // Reference: plain integer subtraction; packed as {ovf, zero, bout, diff}.
    function automatic logic [18:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic bin);
        longint      mask;
        longint      r;
        logic [15:0] d;
        logic        am, bm, dm;
        mask = (longint'(1) << w) - 64'sd1;
        r    = (longint'(a) & mask) - (longint'(b) & mask) - longint'(bin);
        d    = 16'(r & mask);
        am   = a[w-1];
        bm   = b[w-1];
        dm   = d[w-1];
        return {(am != bm) && (dm != am), d == 16'd0, r < 64'sd0, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction on DUT k; 'poke' drives fresh operands while DONE is held.
    task automatic do_tx(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input int gap, input int hold, input bit poke);
        logic [18:0] exp;
        obs_t        o;
        int          t;
        exp = model(wd(k), a, b, bin);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        ia[k] = a; ib[k] = b; ibin[k] = bin; iv[k] = 1'b1;
        t = 0;
        while (!obs(k).ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("hs_ready", 32'(obs(k).ready), 32'd1);
        @(posedge clk);
        #1;
        iv[k] = 1'b0; ia[k] = 16'($urandom); ib[k] = 16'($urandom); ibin[k] = 1'($urandom);
        t = 0;
        while (!obs(k).valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        // Counting the handshake edge itself, out_valid rises on edge WIDTH+1.
        chk("latency", 32'(t), 32'(wd(k)));
        o = obs(k);
        chk("result", 32'({o.ovf, o.zero, o.bout, o.diff}), 32'(exp));
        chk("busy_ready", 32'(o.ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                iv[k] = 1'b1; ia[k] = 16'($urandom); ib[k] = 16'($urandom);
            end
            @(posedge clk);
            #1;
            chk("hold_stable", 32'(obs(k)), 32'(o));
        end
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
        chk("release_valid", 32'(obs(k).valid), 32'd0);
        chk("release_ready", 32'(obs(k).ready), 32'd1);
        chk("retain", 32'({obs(k).ovf, obs(k).zero, obs(k).bout, obs(k).diff}), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ia[k] = 16'd0; ib[k] = 16'd0; ibin[k] = 1'b0; ordy[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("reset_state", 32'(obs(k)), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("idle_ready", 32'(obs(k).ready), 32'd1);

        do_tx(0, 16'h05, 16'h03, 1'b0, 0, 0, 1'b0);
        do_tx(0, 16'h03, 16'h05, 1'b0, 0, 0, 1'b0);
        do_tx(0, 16'h80, 16'h01, 1'b0, 0, 0, 1'b0);
        do_tx(0, 16'h10, 16'h0F, 1'b1, 0, 0, 1'b0);
        do_tx(0, 16'h00, 16'h7F, 1'b1, 0, 0, 1'b0);
        do_tx(0, 16'h5A, 16'h3C, 1'b0, 1, 5, 1'b1);
        do_tx(0, 16'h03, 16'h05, 1'b0, 0, 0, 1'b0);

        // Abort mid-RUN: reset sampled on the third RUN edge.
        @(negedge clk);
        ia[0] = 16'h44; ib[0] = 16'h11; ibin[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_clear", 32'(obs(0)), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready", 32'(obs(0).ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_valid", 32'(obs(0).valid), 32'd0);
        end
        do_tx(0, 16'hFF, 16'hFF, 1'b0, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++)
            do_tx(0, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), 1'($urandom));
        for (int i = 0; i < 1000; i++)
            do_tx(1, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), 1'($urandom));
        for (int i = 0; i < 1000; i++)
            do_tx(2, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
